sha3_stream_sequencer: RTL and testbench

- Controller that sequences the Keccak-f[1600] core for SHA3-224/256/384/512 over 16-bit AXI-Stream.
- Absorb: splits the input stream into rate-sized blocks, writes words into the core, and inserts SHA3 padding (0x06 … 0x80) in hardware.
- Permute: starts each permutation and waits for it to finish.
- Squeeze: streams out the digest words with TLAST.
- Sits between the AXI_SHA stream front-end and the permutation/state core.

---
 rtl/sha3_stream_sequencer_pkg.sv | 47 ++++
 rtl/sha3_stream_sequencer_pad_word.sv | 33 +++
 rtl/sha3_stream_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_sha3_stream_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_stream_sequencer_pkg.sv
// Shared types and constants for the SHA3 stream sequencer: modes, FSM states,
// per-mode rate/digest sizes and the SHA3 domain padding bytes.
package sha3_ctrl_pkg;

  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } sha3_mode_e;

  typedef enum logic [1:0] {
    ABSORB  = 2'd0,
    PAD     = 2'd1,
    PERM    = 2'd2,
    SQUEEZE = 2'd3
  } seq_state_e;

  // Rate in 16-bit words: (1600 - 2*digest_bits) / 16.
  function automatic logic [6:0] rate_words(input sha3_mode_e m);
    logic [6:0] r;
    r = 7'd72;
    case (m)
      MODE_224: r = 7'd72;
      MODE_256: r = 7'd68;
      MODE_384: r = 7'd52;
      MODE_512: r = 7'd36;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] out_words(input sha3_mode_e m);
    logic [5:0] o;
    o = 6'd14;
    case (m)
      MODE_224: o = 6'd14;
      MODE_256: o = 6'd16;
      MODE_384: o = 6'd24;
      MODE_512: o = 6'd32;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sha3_stream_sequencer_pad_word.sv
// Combinational generator of the word written into the rate: raw data for full
// beats, otherwise the data byte (if any) merged with SHA3 padding bytes.
module sha3_pad_word
  import sha3_ctrl_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic [15:0]      data,
  input  logic [1:0]       keep,
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] rate_w,
  input  logic             pad_started,
  output logic [15:0]      word
);

  logic [7:0] hi;
  logic [7:0] lo;
  logic       at_end;

  always_comb begin
    at_end = (idx == rate_w - IDX_W'(1));
    hi     = pad_started ? 8'h00 : PAD_FIRST;
    lo     = 8'h00;
    // A single data byte pushes the 0x06 into the low byte of the same word.
    if (keep[1]) begin
      hi = data[15:8];
      lo = pad_started ? 8'h00 : PAD_FIRST;
    end
    if (at_end) lo = lo | PAD_LAST;
    word = (keep == 2'b11) ? data : {hi, lo};
  end

endmodule

// File: rtl/sha3_stream_sequencer.sv
// Absorb/pad/permute/squeeze sequencer for a Keccak-f[1600] core on a 16-bit stream.
// Define SHA3_PERF_CNT_EN to add the saturating perm_count output.
module sha3_stream_sequencer
  import sha3_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 7
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic [1:0]       s_tkeep,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [WIDTH-1:0] blk_word,
  output logic [IDX_W-1:0] blk_idx,
  output logic             blk_we,
  output logic             perm_start,
  input  logic             perm_done,
  output logic             state_clr,
  output logic [4:0]       rd_idx,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast
`ifdef SHA3_PERF_CNT_EN
  ,
  output logic [31:0]      perm_count
`endif
);

  // Stream handshakes: a beat transfers on a rising edge where valid and ready
  // are both high; the source keeps data stable while valid is high and ready low.

  seq_state_e       state, state_nx;
  logic [IDX_W-1:0] word_cnt, word_cnt_nx;
  logic [4:0]       out_cnt, out_cnt_nx;
  logic             msg_active, msg_active_nx;
  sha3_mode_e       mode_q, mode_nx, cur_mode;
  logic             final_q, final_nx;
  logic             pad_pending, pad_pending_nx;
  logic             pad_started, pad_started_nx;
  logic             we_nx;
  logic [WIDTH-1:0] word_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             start_req, start_req_nx;
  logic             clr_q, clr_nx;

  logic [IDX_W-1:0] rate_w;
  logic [IDX_W-1:0] rate_last;
  logic [4:0]       out_last;
  logic [1:0]       gen_keep;
  logic             gen_started;
  logic [WIDTH-1:0] pad_word;
  logic             s_hs;
  logic             at_rate_end;

  // The mode pin only matters on the first beat; afterwards the latched copy rules.
  assign cur_mode    = msg_active ? mode_q : sha3_mode_e'(mode);
  assign rate_w      = IDX_W'(rate_words(cur_mode));
  assign rate_last   = rate_w - IDX_W'(1);
  assign out_last    = 5'(out_words(cur_mode) - 6'd1);
  assign at_rate_end = (word_cnt == rate_last);

  assign gen_keep    = (state == PAD) ? 2'b00 : (s_tlast ? s_tkeep : 2'b11);
  assign gen_started = (state == PAD) && pad_started;

  sha3_pad_word #(.IDX_W(IDX_W)) u_pad_word (
    .data        (s_tdata),
    .keep        (gen_keep),
    .idx         (word_cnt),
    .rate_w      (rate_w),
    .pad_started (gen_started),
    .word        (pad_word)
  );

  assign s_tready  = (state == ABSORB) && !ARESET;
  assign s_hs      = s_tvalid && s_tready;
  assign m_tvalid  = (state == SQUEEZE);
  assign rd_idx    = out_cnt;
  assign m_tdata   = m_tvalid ? rd_data : '0;
  assign m_tlast   = m_tvalid && (out_cnt == out_last);
  assign state_clr = ARESET || clr_q;

  always_comb begin
    state_nx       = state;
    word_cnt_nx    = word_cnt;
    out_cnt_nx     = out_cnt;
    msg_active_nx  = msg_active;
    mode_nx        = mode_q;
    final_nx       = final_q;
    pad_pending_nx = pad_pending;
    pad_started_nx = pad_started;
    we_nx          = 1'b0;
    word_nx        = '0;
    idx_nx         = '0;
    start_req_nx   = 1'b0;
    clr_nx         = 1'b0;

    case (state)
      ABSORB: begin
        if (s_hs) begin
          if (!msg_active) begin
            msg_active_nx = 1'b1;
            mode_nx       = sha3_mode_e'(mode);
          end
          we_nx  = 1'b1;
          idx_nx = word_cnt;
          word_nx = pad_word;
          if (!s_tlast || s_tkeep == 2'b11) begin
            if (at_rate_end) begin
              // A full block that ends the message leaves a pure-padding block to follow.
              start_req_nx   = 1'b1;
              state_nx       = PERM;
              final_nx       = 1'b0;
              pad_pending_nx = s_tlast;
              pad_started_nx = 1'b0;
              word_cnt_nx    = '0;
            end else begin
              word_cnt_nx = word_cnt + IDX_W'(1);
              if (s_tlast) begin
                state_nx       = PAD;
                pad_started_nx = 1'b0;
              end
            end
          end else if (at_rate_end) begin
            start_req_nx = 1'b1;
            state_nx     = PERM;
            final_nx     = 1'b1;
            word_cnt_nx  = '0;
          end else begin
            state_nx       = PAD;
            pad_started_nx = 1'b1;
            word_cnt_nx    = word_cnt + IDX_W'(1);
          end
        end
      end
      PAD: begin
        we_nx          = 1'b1;
        idx_nx         = word_cnt;
        word_nx        = pad_word;
        pad_started_nx = 1'b1;
        if (at_rate_end) begin
          start_req_nx = 1'b1;
          state_nx     = PERM;
          final_nx     = 1'b1;
          word_cnt_nx  = '0;
        end else begin
          word_cnt_nx = word_cnt + IDX_W'(1);
        end
      end
      PERM: begin
        if (perm_done) begin
          if (final_q) begin
            state_nx   = SQUEEZE;
            out_cnt_nx = '0;
          end else if (pad_pending) begin
            state_nx       = PAD;
            pad_pending_nx = 1'b0;
          end else begin
            state_nx = ABSORB;
          end
        end
      end
      SQUEEZE: begin
        if (m_tready) begin
          if (out_cnt == out_last) begin
            clr_nx        = 1'b1;
            msg_active_nx = 1'b0;
            final_nx      = 1'b0;
            out_cnt_nx    = '0;
            state_nx      = ABSORB;
          end else begin
            out_cnt_nx = out_cnt + 5'd1;
          end
        end
      end
      default: state_nx = ABSORB;
    endcase
  end

  // perm_start trails the block's last write by one cycle so the core sees a complete rate.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= ABSORB;
      word_cnt    <= '0;
      out_cnt     <= '0;
      msg_active  <= 1'b0;
      mode_q      <= MODE_224;
      final_q     <= 1'b0;
      pad_pending <= 1'b0;
      pad_started <= 1'b0;
      blk_we      <= 1'b0;
      blk_word    <= '0;
      blk_idx     <= '0;
      start_req   <= 1'b0;
      perm_start  <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      word_cnt    <= word_cnt_nx;
      out_cnt     <= out_cnt_nx;
      msg_active  <= msg_active_nx;
      mode_q      <= mode_nx;
      final_q     <= final_nx;
      pad_pending <= pad_pending_nx;
      pad_started <= pad_started_nx;
      blk_we      <= we_nx;
      blk_word    <= word_nx;
      blk_idx     <= idx_nx;
      start_req   <= start_req_nx;
      perm_start  <= start_req;
      clr_q       <= clr_nx;
    end
  end

`ifdef SHA3_PERF_CNT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      perm_count <= '0;
    end else if (perm_start && perm_count != 32'hFFFF_FFFF) begin
      perm_count <= perm_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha3_stream_sequencer.sv
// Directed bench for sha3_stream_sequencer: table of messages with hand-computed
// write/digest expectations, plus reset-abort and stall sequences.
module tb_sha3_stream_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [15:0] s_tdata = '0;
  logic [1:0]  s_tkeep = 2'b11;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [15:0] blk_word;
  logic [6:0]  blk_idx;
  logic        blk_we;
  logic        perm_start;
  logic        perm_done = 1'b0;
  logic        state_clr;
  logic [4:0]  rd_idx;
  logic [15:0] rd_data;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
`ifdef SHA3_PERF_CNT_EN
  logic [31:0] perm_count;
`endif

  sha3_stream_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET), .mode(mode),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .blk_word(blk_word), .blk_idx(blk_idx), .blk_we(blk_we),
    .perm_start(perm_start), .perm_done(perm_done), .state_clr(state_clr),
    .rd_idx(rd_idx), .rd_data(rd_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef SHA3_PERF_CNT_EN
    , .perm_count(perm_count)
`endif
  );

  // ---------------- clock / reset-independent core model ----------------
  always #5 ACLK = ~ACLK;

  assign rd_data = {3'b101, rd_idx, 8'h5A};

  int done_cd = 0;
  always @(negedge ACLK) begin
    perm_done = 1'b0;
    if (done_cd == 1) perm_done = 1'b1;
    if (done_cd != 0) done_cd--;
    if (perm_start && !ARESET) done_cd = 6;
  end

  logic toggle_rdy = 1'b0;
  logic rdy_level = 1'b1;
  always @(posedge ACLK) begin
    #1;
    m_tready = toggle_rdy ? ~m_tready : rdy_level;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [22:0] exp_q[$];
  logic [22:0] wr_q[$];
  logic [16:0] out_q[$];
  int perm_seen = 0;
  int clr_seen = 0;
  logic        stall_pend = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESET) begin
      stall_pend = 1'b0;
    end else begin
      if (blk_we) wr_q.push_back({blk_idx, blk_word});
      if (perm_start) perm_seen++;
      if (state_clr) clr_seen++;
      if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
      if (stall_pend) begin
        check("stall_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_data", {15'd0, m_tlast, m_tdata}, {15'd0, stall_last, stall_data});
      end
      stall_pend = m_tvalid && !m_tready;
      stall_data = m_tdata;
      stall_last = m_tlast;
    end
  end

  // ---------------- vectors and model ----------------
  typedef struct {
    logic [1:0]  md;
    int          n;
    logic [1:0]  k;
    logic [15:0] last_data;
    logic        toggle;
    int          n_wr;
    int          n_perm;
    int          n_out;
    int          key_pos;
    logic [6:0]  key_idx;
    logic [15:0] key_word;
  } vec_t;

  vec_t vecs[8];

  function automatic int rate_of(input logic [1:0] md);
    case (md)
      2'd0: return 72;
      2'd1: return 68;
      2'd2: return 52;
      default: return 36;
    endcase
  endfunction

  function automatic logic [15:0] dword(input int i);
    return 16'h1234 + 16'(i) * 16'h0101;
  endfunction

  task automatic pad_fill(input int from, input int r, input bit started);
    for (int j = from; j < r; j++) begin
      logic [15:0] w;
      w = {(started ? 8'h00 : 8'h06), ((j == r - 1) ? 8'h80 : 8'h00)};
      exp_q.push_back({7'(j), w});
      started = 1'b1;
    end
  endtask

  task automatic build_exp(input vec_t v);
    int r;
    int cnt;
    r = rate_of(v.md);
    cnt = 0;
    exp_q.delete();
    for (int i = 0; i < v.n - 1; i++) begin
      exp_q.push_back({7'(cnt), dword(i)});
      cnt = (cnt == r - 1) ? 0 : cnt + 1;
    end
    case (v.k)
      2'b11: begin
        exp_q.push_back({7'(cnt), v.last_data});
        if (cnt == r - 1) pad_fill(0, r, 1'b0);
        else pad_fill(cnt + 1, r, 1'b0);
      end
      2'b10: begin
        exp_q.push_back({7'(cnt), v.last_data[15:8], ((cnt == r - 1) ? 8'h86 : 8'h06)});
        if (cnt != r - 1) pad_fill(cnt + 1, r, 1'b1);
      end
      default: pad_fill(cnt, r, 1'b0);
    endcase
  endtask

  // ---------------- drivers ----------------
  task automatic send_msg(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      int g;
      g = 0;
      mode     = (i == 0) ? v.md : ~v.md;
      s_tvalid = 1'b1;
      s_tlast  = (i == v.n - 1);
      s_tkeep  = (i == v.n - 1) ? v.k : 2'b11;
      s_tdata  = (i == v.n - 1) ? v.last_data : dword(i);
      forever begin
        @(negedge ACLK);
        if (s_tready || g >= 4000) break;
        @(posedge ACLK);
        #1;
        g++;
      end
      if (g >= 4000) check("beat_timeout", 32'd1, 32'd0);
      @(posedge ACLK);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int n_out, input int clr0);
    int g;
    g = 0;
    while ((out_q.size() < n_out || clr_seen == clr0) && g < 4000) begin
      @(posedge ACLK);
      g++;
    end
    if (g >= 4000) check("done_timeout", 32'd1, 32'd0);
    repeat (4) @(posedge ACLK);
    #1;
  endtask

  task automatic run_vector(input int id, input vec_t v);
    int p0;
    int c0;
    build_exp(v);
    wr_q.delete();
    out_q.delete();
    p0 = perm_seen;
    c0 = clr_seen;
    toggle_rdy = v.toggle;
    send_msg(v);
    wait_done(v.n_out, c0);
    toggle_rdy = 1'b0;
    check($sformatf("v%0d_nwr_model", id), wr_q.size(), exp_q.size());
    check($sformatf("v%0d_nwr", id), wr_q.size(), v.n_wr);
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check($sformatf("v%0d_wr%0d", id, i), {9'd0, wr_q[i]}, {9'd0, exp_q[i]});
    if (v.key_pos < wr_q.size())
      check($sformatf("v%0d_key", id), {9'd0, wr_q[v.key_pos]}, {9'd0, v.key_idx, v.key_word});
    else
      check($sformatf("v%0d_key_missing", id), wr_q.size(), v.key_pos + 1);
    check($sformatf("v%0d_perms", id), perm_seen - p0, v.n_perm);
    check($sformatf("v%0d_nout", id), out_q.size(), v.n_out);
    for (int j = 0; j < out_q.size() && j < v.n_out; j++)
      check($sformatf("v%0d_out%0d", id, j), {15'd0, out_q[j]},
            {15'd0, (j == v.n_out - 1), 3'b101, 5'(j), 8'h5A});
    check($sformatf("v%0d_clr_once", id), clr_seen - c0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int out0;
    vecs[0] = '{2'd0, 1,  2'b00, 16'h0000, 1'b0, 72,  1, 14, 71, 7'd71, 16'h0080};
    vecs[1] = '{2'd1, 67, 2'b11, 16'h5151, 1'b0, 68,  1, 16, 67, 7'd67, 16'h0680};
    vecs[2] = '{2'd3, 36, 2'b11, 16'h3636, 1'b0, 72,  2, 32, 36, 7'd0,  16'h0600};
    vecs[3] = '{2'd2, 52, 2'b10, 16'hABCD, 1'b0, 52,  1, 24, 51, 7'd51, 16'hAB86};
    vecs[4] = '{2'd1, 3,  2'b10, 16'h7700, 1'b0, 68,  1, 16, 2,  7'd2,  16'h7706};
    vecs[5] = '{2'd0, 72, 2'b00, 16'h0000, 1'b0, 72,  1, 14, 71, 7'd71, 16'h0680};
    vecs[6] = '{2'd2, 53, 2'b11, 16'h5353, 1'b0, 104, 2, 24, 53, 7'd1,  16'h0600};
    vecs[7] = '{2'd3, 1,  2'b00, 16'h0000, 1'b1, 36,  1, 32, 35, 7'd35, 16'h0080};

    // reset state
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_s_tready", {31'd0, s_tready}, 32'd0);
    check("rst_state_clr", {31'd0, state_clr}, 32'd1);
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_blk_we", {31'd0, blk_we}, 32'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("idle_s_tready", {31'd0, s_tready}, 32'd1);
    check("idle_state_clr", {31'd0, state_clr}, 32'd0);
    check("idle_outs", {24'd0, perm_start, m_tlast, rd_idx, blk_we}, 32'd0);
    @(posedge ACLK);
    #1;

    for (int v = 0; v < 8; v++) run_vector(v, vecs[v]);

    // reset while waiting for the permutation; the late perm_done must be ignored
    wr_q.delete();
    out_q.delete();
    out0 = perm_seen;
    send_msg(vecs[0]);
    g = 0;
    while (perm_seen == out0 && g < 400) begin
      @(posedge ACLK);
      g++;
    end
    if (g >= 400) check("perm_wait_timeout", 32'd1, 32'd0);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("rperm_outs", {28'd0, m_tvalid, s_tready, blk_we, perm_start}, 32'd0);
    check("rperm_clr", {31'd0, state_clr}, 32'd1);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    wr_q.delete();
    out0 = perm_seen;
    repeat (20) @(posedge ACLK);
    @(negedge ACLK);
    check("rperm_no_squeeze", out_q.size(), 0);
    check("rperm_no_writes", wr_q.size(), 0);
    check("rperm_no_perm", perm_seen - out0, 0);
    check("rperm_ready", {31'd0, s_tready}, 32'd1);
    @(posedge ACLK);
    #1;

    // reset mid-squeeze with the sink stalled
    out_q.delete();
    send_msg(vecs[1]);
    g = 0;
    while (out_q.size() < 3 && g < 600) begin
      @(posedge ACLK);
      g++;
    end
    if (g >= 600) check("sq_wait_timeout", 32'd1, 32'd0);
    #1;
    rdy_level = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    out0 = out_q.size();
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("rsq_outs", {28'd0, m_tvalid, m_tlast, rd_idx != 5'd0, s_tready}, 32'd0);
    check("rsq_clr", {31'd0, state_clr}, 32'd1);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    rdy_level = 1'b1;
    repeat (20) @(posedge ACLK);
    check("rsq_no_partial", out_q.size(), out0);
    #1;

    // fresh empty message after the aborts
    run_vector(8, vecs[0]);
`ifdef SHA3_PERF_CNT_EN
    check("perm_count", perm_count, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
